// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
//
// Multi-channel PWM peripheral with a simple single-cycle register bus.
// A 16-bit prescaler produces a tick. Each tick advances a shared period
// counter that wraps at PERIOD. Each channel compares the counter against
// its own compare value to produce a PWM pin.
//
// Compare values are double-buffered. The bus writes a shadow copy, and the
// shadow moves into the active copy only at a period wrap (or continuously
// while disabled), so a mid-period update never produces a glitch.
//
// Register map (byte offsets, only bAddr[5:2] decoded):
//   0x00 CTRL      bit0 EN, bit1 IE, bits[8+CHANNELS-1:8] POL (per-channel invert)
//   0x04 PRESCALE  [15:0]
//   0x08 PERIOD    [WIDTH-1:0]
//   0x0C STATUS    bit0 WRAP (write 1 to clear)
//   0x10+4*i       COMPARE[i] [WIDTH-1:0], reads return the shadow value
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   rst_n      synchronous active-low reset
//   bSel       bus select
//   bAddr      byte address
//   bWrite     write strobe (write happens when bSel & bWrite)
//   bWData     write data
//   bRData     read data, combinational from bAddr and register state
//   pwmOutput  registered PWM pins, one per channel
//   irq        registered interrupt request (WRAP & IE)
//
// Legal parameter ranges: WIDTH 2..16, CHANNELS 1..8.
// -----------------------------------------------------------------------------
module pwm_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bSel,
    input  logic [31:0]         bAddr,
    input  logic                bWrite,
    input  logic [31:0]         bWData,
    output logic [31:0]         bRData,
    output logic [CHANNELS-1:0] pwmOutput,
    output logic                irq
);

    // Word index of each register within the 16-word window.
    localparam logic [3:0] REG_CTRL     = 4'd0;
    localparam logic [3:0] REG_PRESCALE = 4'd1;
    localparam logic [3:0] REG_PERIOD   = 4'd2;
    localparam logic [3:0] REG_STATUS   = 4'd3;
    localparam logic [3:0] REG_CMP_BASE = 4'd4;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic                en;
    logic                ie;
    logic [CHANNELS-1:0] pol;
    logic [15:0]         prescale;
    logic [WIDTH-1:0]    period;
    logic                wrapFlag;
    logic [WIDTH-1:0]    shadowCmp [CHANNELS];
    logic [WIDTH-1:0]    activeCmp [CHANNELS];

    // Counters
    logic [15:0]         pscnt;
    logic [WIDTH-1:0]    cnt;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [3:0]          regIdx;
    logic                wrEn;
    logic                wrCtrl;
    logic                wrPrescale;
    logic                wrPeriod;
    logic                wrStatus;
    logic [CHANNELS-1:0] wrCmp;

    assign regIdx     = bAddr[5:2];
    assign wrEn       = bSel & bWrite;
    assign wrCtrl     = wrEn && (regIdx == REG_CTRL);
    assign wrPrescale = wrEn && (regIdx == REG_PRESCALE);
    assign wrPeriod   = wrEn && (regIdx == REG_PERIOD);
    assign wrStatus   = wrEn && (regIdx == REG_STATUS);

    // NOTE: every signal driven in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wrCmp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wrEn && (regIdx == REG_CMP_BASE + 4'(i))) begin
                wrCmp[i] = 1'b1;
            end
        end
    end

    // Address bits outside [5:2] and the upper write-data half carry no
    // meaning for this block; fold them into one deliberately unused net.
    logic unusedBusBits;
    assign unusedBusBits = ^{bAddr[31:6], bAddr[1:0], bWData[31:16]};

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    logic tick;
    logic wrapEvent;

    // The >= comparison makes a PERIOD write below the current count wrap
    // on the very next tick instead of running on to 2^WIDTH.
    assign tick      = en && (pscnt == prescale);
    assign wrapEvent = tick && (cnt >= period);

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en       <= 1'b0;
            ie       <= 1'b0;
            pol      <= '0;
            prescale <= '0;
            period   <= '1;
        end else begin
            if (wrCtrl) begin
                en  <= bWData[0];
                ie  <= bWData[1];
                pol <= bWData[8 +: CHANNELS];
            end
            if (wrPrescale) begin
                prescale <= bWData[15:0];
            end
            if (wrPeriod) begin
                period <= bWData[WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare registers: bus-written shadows, wrap-loaded actives
    // ------------------------------------------------------------------
    // NOTE: the compare arrays are a handful of flops, not a RAM, so they are
    // reset explicitly element by element.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadowCmp[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wrCmp[i]) begin
                    shadowCmp[i] <= bWData[WIDTH-1:0];
                end
            end
        end
    end

    // Actives track the shadows continuously while disabled, so enabling
    // starts the first period with the latest programmed duty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                activeCmp[i] <= '0;
            end
        end else if (wrapEvent || !en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                activeCmp[i] <= shadowCmp[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and period counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pscnt <= '0;
            cnt   <= '0;
        end else if (!en) begin
            pscnt <= '0;
            cnt   <= '0;
        end else if (tick) begin
            pscnt <= '0;
            cnt   <= wrapEvent ? '0 : cnt + WIDTH'(1);
        end else begin
            pscnt <= pscnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Wrap flag and interrupt
    // ------------------------------------------------------------------
    // A wrap in the same cycle as a clear keeps the flag set, so no event
    // is ever lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrapFlag <= 1'b0;
        end else if (wrapEvent) begin
            wrapFlag <= 1'b1;
        end else if (wrStatus && bWData[0]) begin
            wrapFlag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= wrapFlag & ie;
        end
    end

    // ------------------------------------------------------------------
    // PWM outputs
    // ------------------------------------------------------------------
    // cnt < compare gives 0% duty at COMPARE=0, 100% duty when
    // COMPARE > PERIOD, and otherwise COMPARE high counts per period.
    logic [CHANNELS-1:0] cmpLess;

    always_comb begin
        cmpLess = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cmpLess[i] = (cnt < activeCmp[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwmOutput <= '0;
        end else if (en) begin
            pwmOutput <= cmpLess ^ pol;
        end else begin
            pwmOutput <= pol;
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] ctrlRead;

    always_comb begin
        ctrlRead              = '0;
        ctrlRead[0]           = en;
        ctrlRead[1]           = ie;
        ctrlRead[8 +: CHANNELS] = pol;
    end

    always_comb begin
        bRData = '0;
        case (regIdx)
            REG_CTRL:     bRData = ctrlRead;
            REG_PRESCALE: bRData = 32'(prescale);
            REG_PERIOD:   bRData = 32'(period);
            REG_STATUS:   bRData = 32'(wrapFlag);
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (regIdx == REG_CMP_BASE + 4'(i)) begin
                        bRData = 32'(shadowCmp[i]);
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi
//
// Scoreboard bench for pwm_multi (WIDTH=8, CHANNELS=4). The stimulus thread
// pushes hand-computed expectations, stamped with the cycle they apply to,
// into a queue. A monitor on the falling edge pops every entry due in the
// current cycle and compares it against bRData, pwmOutput or irq.
// -----------------------------------------------------------------------------
module tb_pwm_multi;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;

    localparam logic [31:0] A_CTRL     = 32'h00;
    localparam logic [31:0] A_PRESCALE = 32'h04;
    localparam logic [31:0] A_PERIOD   = 32'h08;
    localparam logic [31:0] A_STATUS   = 32'h0C;
    localparam logic [31:0] A_CMP0     = 32'h10;

    localparam int K_RD  = 0;
    localparam int K_PWM = 1;
    localparam int K_IRQ = 2;

    logic                clk;
    logic                rst_n;
    logic                bSel;
    logic [31:0]         bAddr;
    logic                bWrite;
    logic [31:0]         bWData;
    logic [31:0]         bRData;
    logic [CHANNELS-1:0] pwmOutput;
    logic                irq;

    pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bSel      (bSel),
        .bAddr     (bAddr),
        .bWrite    (bWrite),
        .bWData    (bWData),
        .bRData    (bRData),
        .pwmOutput (pwmOutput),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed pin patterns {ch3,ch2,ch1,ch0} per counter phase.
    // PERIOD=9, COMPARE = {5,10,0,3}, then COMPARE0 becomes 6.
    logic [3:0] dutyA [10] = '{4'b1101, 4'b1101, 4'b1101, 4'b1100, 4'b1100,
                               4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    logic [3:0] dutyB [10] = '{4'b1101, 4'b1101, 4'b1101, 4'b1101, 4'b1101,
                               4'b0101, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    // PRESCALE=2, PERIOD=3: counter value after m edges, and the thermometer
    // pattern that COMPARE = {4,3,2,1} produces for each counter value.
    int         cntTab [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    logic [3:0] therm  [4]  = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
    // Period shrink / disable / re-enable window, k = 199..212.
    logic [3:0] shrink [14] = '{4'b1001, 4'b1001, 4'b1001, 4'b1011, 4'b1001,
                                4'b1001, 4'b1001, 4'b1001, 4'b1000, 4'b1000,
                                4'b1000, 4'b1000, 4'b1011, 4'b1001};

    typedef struct {
        string       name;
        int          kind;
        int          cyc;
        logic [31:0] mask;
        logic [31:0] exp;
    } exp_t;

    exp_t sbQ [$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    exp_t        mon;
    logic [31:0] monAct;

    always @(negedge clk) begin
        while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
            mon = sbQ.pop_front();
            if (mon.cyc != cyc) begin
                check($sformatf("%s_stale", mon.name), 32'(cyc), 32'(mon.cyc));
            end else begin
                case (mon.kind)
                    K_RD:    monAct = bRData;
                    K_PWM:   monAct = 32'(pwmOutput);
                    default: monAct = 32'(irq);
                endcase
                check(mon.name, monAct & mon.mask, mon.exp);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge + 1)
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
        bSel   = 1'b0;
        bWrite = 1'b0;
        bWData = '0;
    endtask

    task automatic push(input string name, input int kind, input logic [31:0] mask,
                        input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.cyc  = cyc;
        e.mask = mask;
        e.exp  = exp & mask;
        sbQ.push_back(e);
    endtask

    task automatic expectPwm(input string name, input logic [3:0] mask, input logic [3:0] exp);
        push(name, K_PWM, 32'(mask), 32'(exp));
    endtask

    task automatic expectIrq(input string name, input logic exp);
        push(name, K_IRQ, 32'h1, 32'(exp));
    endtask

    task automatic readNow(input string name, input logic [31:0] addr, input logic [31:0] exp);
        bAddr = addr;
        push(name, K_RD, 32'hFFFF_FFFF, exp);
    endtask

    task automatic expectRead(input string name, input logic [31:0] addr, input logic [31:0] exp);
        readNow(name, addr, exp);
        step();
    endtask

    task automatic driveWrite(input logic [31:0] addr, input logic [31:0] data);
        bSel   = 1'b1;
        bWrite = 1'b1;
        bAddr  = addr;
        bWData = data;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        driveWrite(addr, data);
        step();
    endtask

    task automatic checkReset(input string tag);
        expectPwm($sformatf("%s_pwm", tag), 4'hF, 4'h0);
        expectIrq($sformatf("%s_irq", tag), 1'b0);
        expectRead($sformatf("%s_ctrl", tag), A_CTRL, 32'h0);
        expectRead($sformatf("%s_prescale", tag), A_PRESCALE, 32'h0);
        expectRead($sformatf("%s_period", tag), A_PERIOD, 32'hFF);
        expectRead($sformatf("%s_status", tag), A_STATUS, 32'h0);
        for (int i = 0; i < CHANNELS; i++) begin
            expectRead($sformatf("%s_cmp%0d", tag, i), A_CMP0 + 32'(4 * i), 32'h0);
        end
        expectPwm($sformatf("%s_pwm_hold", tag), 4'hF, 4'h0);
        step();
    endtask

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_n  = 1'b0;
        bSel   = 1'b0;
        bWrite = 1'b0;
        bAddr  = '0;
        bWData = '0;
        step();
        step();
        rst_n = 1'b1;

        // Reset values, unmapped offsets, no aliasing of 0x20 onto CTRL.
        checkReset("por");
        busWrite(32'h20, 32'hFFFF_FFFF);
        expectRead("unmapped_20", 32'h20, 32'h0);
        expectRead("alias_ctrl", A_CTRL, 32'h0);
        expectRead("unmapped_3c", 32'h3C, 32'h0);

        // Duty, boundary duties and mid-period shadow update.
        busWrite(A_PERIOD, 32'd9);
        busWrite(A_CMP0 + 32'h0, 32'd3);
        busWrite(A_CMP0 + 32'h4, 32'd0);
        busWrite(A_CMP0 + 32'h8, 32'd10);
        busWrite(A_CMP0 + 32'hC, 32'd5);
        busWrite(A_CTRL, 32'h1);
        step();
        for (int j = 0; j < 40; j++) begin
            expectPwm($sformatf("duty_j%0d", j), 4'hF, (j < 30) ? dutyA[j % 10] : dutyB[j % 10]);
            if (j == 24) driveWrite(A_CMP0, 32'd6);
            step();
        end

        // Inverting channel 1 turns its 0% into constant 1.
        busWrite(A_CTRL, 32'h201);
        step();
        for (int j = 0; j < 10; j++) begin
            expectPwm($sformatf("pol1_%0d", j), 4'b0110, 4'b0110);
            step();
        end
        expectRead("ctrl_pol1", A_CTRL, 32'h201);
        expectRead("cmp0_shadow", A_CMP0, 32'd6);

        // Disable with all bits set: only defined CTRL bits read back,
        // pins follow POL, WRAP survives, then clear it.
        busWrite(A_CTRL, 32'hFFFF_FFFC);
        expectRead("ctrl_mask", A_CTRL, 32'h0000_0F00);
        expectPwm("dis_pol", 4'hF, 4'hF);
        expectRead("wrap_kept", A_STATUS, 32'h1);
        busWrite(A_STATUS, 32'h1);
        expectRead("wrap_clr", A_STATUS, 32'h0);

        // Prescaler, wrap flag, interrupt timing, set-wins-over-clear.
        busWrite(A_CTRL, 32'h0);
        busWrite(A_PRESCALE, 32'd2);
        busWrite(A_PERIOD, 32'd3);
        for (int i = 0; i < CHANNELS; i++) begin
            busWrite(A_CMP0 + 32'(4 * i), 32'(i + 1));
        end
        busWrite(A_CTRL, 32'h3);
        for (int k = 0; k < 28; k++) begin
            readNow($sformatf("ps_status_k%0d", k), A_STATUS, 32'(k >= 12 && k <= 25));
            expectIrq($sformatf("ps_irq_k%0d", k), (k >= 13 && k <= 26));
            expectPwm($sformatf("ps_pwm_k%0d", k), 4'hF,
                      (k == 0) ? 4'h0 : therm[cntTab[(k - 1) % 12]]);
            if (k == 23 || k == 25) begin
                bSel   = 1'b1;
                bWrite = 1'b1;
                bWData = 32'h1;
            end
            step();
        end

        // Period shrink below the running count, then disable/re-enable.
        busWrite(A_CTRL, 32'h0);
        busWrite(A_STATUS, 32'h1);
        expectRead("p5_status", A_STATUS, 32'h0);
        busWrite(A_PRESCALE, 32'd0);
        busWrite(A_PERIOD, 32'hFF);
        busWrite(A_CMP0 + 32'h0, 32'd201);
        busWrite(A_CMP0 + 32'h4, 32'd1);
        busWrite(A_CMP0 + 32'h8, 32'd0);
        busWrite(A_CMP0 + 32'hC, 32'd0);
        busWrite(A_CTRL, 32'h801);
        repeat (199) step();
        for (int k = 199; k < 213; k++) begin
            expectPwm($sformatf("shrink_k%0d", k), 4'hF, shrink[k - 199]);
            case (k)
                199:     driveWrite(A_PERIOD, 32'd50);
                200:     readNow("shrink_status_pre", A_STATUS, 32'h0);
                201:     readNow("shrink_status_wrap", A_STATUS, 32'h1);
                205:     driveWrite(A_CTRL, 32'h800);
                208:     readNow("shrink_status_dis", A_STATUS, 32'h1);
                209:     driveWrite(A_CTRL, 32'h801);
                default: ;
            endcase
            step();
        end

        // Mid-run reset with irq and an inverted pin active.
        busWrite(A_PRESCALE, 32'd5);
        busWrite(A_CTRL, 32'h803);
        step();
        expectIrq("pre_rst_irq", 1'b1);
        expectPwm("pre_rst_pwm", 4'b1000, 4'b1000);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkReset("mid");

        step();
        step();
        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending, expected 0", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
PWM_MULTI -- requirements
Module: sm_pwm_multi

Interface
REQ-001 Parameter WIDTH, default 8: counter, period and compare width; legal range 2..16.
REQ-002 Parameter CHANNELS, default 4: number of PWM outputs; legal range 1..8.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 bSel  input  1  bus select for this peripheral.
REQ-006 bAddr  input  32  byte address; only bAddr[5:2] is decoded.
REQ-007 bWrite  input  1  write strobe; a write occurs when bSel & bWrite.
REQ-008 bWData  input  32  write data.
REQ-009 bRData  output  32  read data, combinational from bAddr and register state.
REQ-010 pwmOutput  output  CHANNELS  PWM pins, registered.
REQ-011 irq  output  1  period-wrap interrupt request, registered.

Function
REQ-012 The register map SHALL be: 0x00 CTRL; 0x04 PRESCALE [15:0]; 0x08 PERIOD [WIDTH-1:0]; 0x0C STATUS; 0x10+4*i COMPARE[i] [WIDTH-1:0], for i < CHANNELS.
REQ-013 CTRL SHALL be: bit0 EN; bit1 IE; bits[8+CHANNELS-1:8] POL, one per-channel invert bit; all other bits read 0.
REQ-014 Reads SHALL return register contents zero-extended to 32 bits; COMPARE reads SHALL return the shadow value; STATUS bit0 is WRAP; unmapped offsets SHALL read 0 and ignore writes.
REQ-015 A prescale counter pscnt (16 bit) SHALL assert tick when EN=1 and pscnt==PRESCALE, then clear; otherwise it increments while EN=1; PRESCALE=0 gives a tick every cycle.
REQ-016 On tick, the main counter cnt SHALL increment, except when cnt>=PERIOD, in which case it SHALL load 0 (a wrap event).
REQ-017 Comparison is >= rather than ==, so writing PERIOD below the current cnt SHALL cause a wrap on the next tick; there is no runaway to 2^WIDTH.
REQ-018 Each channel SHALL have a shadow compare, written by the bus, and an active compare, used by the output logic.
REQ-019 Active compares SHALL load from the shadows on a wrap event, and on every cycle while EN=0; a mid-period write therefore takes effect only at the next period start.
REQ-020 On each cycle, pwmOutput[i] SHALL register ((cnt < active[i]) XOR POL[i]) when EN=1, and POL[i] when EN=0.
REQ-021 The compare/cnt relationship SHALL yield: COMPARE=0 gives 0% duty; COMPARE>PERIOD gives 100% duty; otherwise high for COMPARE of PERIOD+1 counts, with POL=0.
REQ-022 A wrap event SHALL set WRAP; writing STATUS with bit0=1 clears WRAP; if a set and a clear occur in the same cycle, set SHALL win.
REQ-023 irq SHALL be registered as WRAP & IE and update one cycle after WRAP changes.
REQ-024 Writing CTRL with EN=0 SHALL clear cnt and pscnt on the next edge and hold them at 0 while EN=0; WRAP SHALL keep its value.
REQ-025 All arithmetic SHALL be unsigned at the declared widths; the cnt increment never exceeds PERIOD, so no overflow is possible.
REQ-026 Bus writes SHALL take effect on the clock edge following the cycle in which bSel & bWrite is sampled; there are no wait states.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL set: CTRL=0; PRESCALE=0; PERIOD=all ones; all shadow and active compares=0; cnt=0; pscnt=0; WRAP=0; pwmOutput=0; irq=0.
REQ-028 Reset asserted mid-period SHALL abort the period immediately; after release, outputs SHALL stay at POL (now 0) until EN is written to 1.

Verification (WIDTH=8, CHANNELS=4)
REQ-029 Duty check: PERIOD=9, PRESCALE=0, COMPARE0=3, EN=1 -> pwmOutput[0] high 3 cycles, low 7 cycles, repeating with period 10.
REQ-030 Boundary duties: COMPARE1=0 and COMPARE2=10 with PERIOD=9 -> ch1 constantly 0 and ch2 constantly 1; then set POL1=1 -> ch1 constantly 1.
REQ-031 Shadow update: COMPARE0 changes 3->6 at cnt=5 -> the current period keeps 3 high cycles; the next period shows 6 high cycles; no glitch.
REQ-032 Prescaler and wrap flag: PRESCALE=2, PERIOD=3 -> cnt advances every 3 cycles and wraps every 12 cycles; with IE=1, irq rises 1 cycle after WRAP; writing STATUS with bit0=1 on a wrap cycle leaves WRAP=1.
REQ-033 Period shrink and disable: at cnt=200 with PERIOD=255, write PERIOD=50 -> cnt=0 on the next tick; write EN=0 -> cnt=0 and pwmOutput=POL on the following cycle.
REQ-034 Reset: assert rst_n=0 for 1 cycle mid-run -> all registers read their reset values (PERIOD reads 0xFF), and pwmOutput=0 and irq=0 on the next cycle.
